// File: rtl/digi_ota_drv.sv
// rtl/digi_ota_drv.sv - pulse-density differential OTA driver with dead time and read-back counter
// Bursts are framed by DEAD idle-drive cycles; vip follows the carry of a code accumulator.
module digi_ota_drv #(
    parameter int DEAD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic [7:0] len,
    input  logic       start_valid,
    output logic       start_ready,
    output logic       vip,
    output logic       vin,
    output logic       drv_oe,
    input  logic       ota_out,
    output logic [8:0] ones,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        DEAD_IN,
        RUN,
        DEAD_OUT
    } state_t;

    localparam logic [3:0] DEAD_LAST = (DEAD == 0) ? 4'd0 : 4'(DEAD - 1);

    state_t     state, state_nxt;
    logic [3:0] dcnt, dcnt_nxt;
    logic [7:0] rcnt, rcnt_nxt;
    logic [7:0] acc, acc_nxt;
    logic [7:0] code_q, code_nxt;
    logic [7:0] len_q, len_nxt;
    logic [8:0] ones_nxt;
    logic [8:0] sum_nxt;
    logic       vip_nxt, vin_nxt, oe_nxt, done_nxt, ready_nxt;
    logic       sync1, sync2;
    logic       accept;

    assign accept = start_valid && start_ready;

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        rcnt_nxt  = rcnt;
        acc_nxt   = acc;
        code_nxt  = code_q;
        len_nxt   = len_q;
        ones_nxt  = ones;

        case (state)
            IDLE: begin
                if (accept) begin
                    code_nxt = code;
                    len_nxt  = len;
                    acc_nxt  = 8'd0;
                    ones_nxt = 9'd0;
                    if (DEAD == 0) begin
                        state_nxt = RUN;
                        // len-1 wraps to 255 for len=0, giving 256 RUN cycles
                        rcnt_nxt  = len - 8'd1;
                    end else begin
                        state_nxt = DEAD_IN;
                        dcnt_nxt  = DEAD_LAST;
                    end
                end
            end
            DEAD_IN: begin
                if (dcnt == 4'd0) begin
                    state_nxt = RUN;
                    rcnt_nxt  = len_q - 8'd1;
                    acc_nxt   = 8'd0;
                end else begin
                    dcnt_nxt = dcnt - 4'd1;
                end
            end
            RUN: begin
                if (sync2 && (ones != 9'd256)) begin
                    ones_nxt = ones + 9'd1;
                end
                if (rcnt == 8'd0) begin
                    if (DEAD == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DEAD_OUT;
                        dcnt_nxt  = DEAD_LAST;
                    end
                end else begin
                    rcnt_nxt = rcnt - 8'd1;
                    acc_nxt  = acc + code_q;
                end
            end
            DEAD_OUT: begin
                if (dcnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are precomputed from the upcoming state so they leave a flop.
        sum_nxt   = {1'b0, acc_nxt} + {1'b0, code_nxt};
        vip_nxt   = (state_nxt == RUN) && sum_nxt[8];
        vin_nxt   = (state_nxt == RUN) && !sum_nxt[8];
        oe_nxt    = (state_nxt != IDLE);
        ready_nxt = (state_nxt == IDLE);
        done_nxt  = (state != IDLE) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dcnt        <= 4'd0;
            rcnt        <= 8'd0;
            acc         <= 8'd0;
            code_q      <= 8'd0;
            len_q       <= 8'd0;
            ones        <= 9'd0;
            vip         <= 1'b0;
            vin         <= 1'b0;
            drv_oe      <= 1'b0;
            done        <= 1'b0;
            start_ready <= 1'b1;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
        end else begin
            state       <= state_nxt;
            dcnt        <= dcnt_nxt;
            rcnt        <= rcnt_nxt;
            acc         <= acc_nxt;
            code_q      <= code_nxt;
            len_q       <= len_nxt;
            ones        <= ones_nxt;
            vip         <= vip_nxt;
            vin         <= vin_nxt;
            drv_oe      <= oe_nxt;
            done        <= done_nxt;
            start_ready <= ready_nxt;
            sync1       <= ota_out;
            sync2       <= sync1;
        end
    end

endmodule

// File: doc/digi_ota_drv.md
DIGI_OTA_DRV -- requirements
Module: digi_ota_drv

Interface
REQ-001 SHALL have parameter DEAD, default 2, dead-time cycles (0..15) with drv_oe=1 and vip=vin=0 before and after each burst.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port code  input  8  pulse-density code latched at accept.
REQ-005 SHALL have port len  input  8  burst length in RUN cycles latched at accept (0 means 256).
REQ-006 SHALL have port start_valid  input  1  burst request.
REQ-007 SHALL have port start_ready  output  1  high only in IDLE.
REQ-008 SHALL have port vip  output  1  positive differential drive to the OTA.
REQ-009 SHALL have port vin  output  1  negative differential drive to the OTA.
REQ-010 SHALL have port drv_oe  output  1  analog pad drive enable.
REQ-011 SHALL have port ota_out  input  1  asynchronous OTA output read-back.
REQ-012 SHALL have port ones  output  9  count of high read-back samples in the last burst.
REQ-013 SHALL have port done  output  1  one-cycle end-of-burst pulse.

Function
REQ-014 SHALL implement states IDLE, DEAD_IN, RUN, DEAD_OUT; all outputs registered.
REQ-015 SHALL accept a burst on a clock edge with start_valid=1 and start_ready=1: latch code and len, clear accumulator (8 bit) and ones, go to DEAD_IN (RUN if DEAD=0).
REQ-016 SHALL ignore start_valid outside IDLE; no queuing.
REQ-017 SHALL hold drv_oe=1 in DEAD_IN, RUN, DEAD_OUT and drv_oe=0 in IDLE.
REQ-018 SHALL stay in DEAD_IN and DEAD_OUT exactly DEAD cycles each, with vip=vin=0.
REQ-019 SHALL stay in RUN exactly L cycles (L=len, or 256 if len=0).
REQ-020 SHALL in RUN cycle k (k=0..L-1) present vip = carry of 9-bit sum acc+code, where acc holds (k*code) mod 256, and vin = NOT vip.
REQ-021 SHALL therefore give vip high in exactly floor(L*code/256) RUN cycles; code=0 gives vip always 0; code=255, L=256 gives vip high 255 times.
REQ-022 SHALL never drive vip=1 and vin=1 in the same cycle.
REQ-023 SHALL synchronize ota_out through two flops and add 1 to ones for each RUN cycle in which the synchronized value is 1; ones saturates at 256 and fits 9 bits.
REQ-024 SHALL count only samples taken during RUN cycles; samples from dead time are excluded.
REQ-025 SHALL on leaving DEAD_OUT (RUN if DEAD=0) enter IDLE, pulse done for exactly that transition's following cycle, and hold ones until the next accept.
REQ-026 SHALL allow an accept in the same cycle done is high.

Reset
REQ-027 SHALL on rst=1 immediately (without a clock) force state IDLE, vip=vin=drv_oe=done=0, ones=0, accumulator=0, synchronizer=0.
REQ-028 SHALL present start_ready=1 from release of rst (IDLE).
REQ-029 SHALL on rst mid-burst abort with no done pulse and no retained burst state.

Verification
REQ-030 Reset: assert rst mid-idle and after a burst -> vip=vin=drv_oe=done=0, ones=0, start_ready=1.
REQ-031 code=128, len=8, DEAD=2, ota_out=1 -> drv_oe high 12 cycles; vip in RUN = 0,1,0,1,0,1,0,1; vin complementary; ones=8; done one cycle.
REQ-032 code=255, len=0 -> 256 RUN cycles, vip high 255, vin high 1, never both high.
REQ-033 code=0, len=16, ota_out=0 -> vip 0 and vin 1 for all 16 RUN cycles, ones=0.
REQ-034 start_valid held high continuously -> back-to-back bursts; each accept only in IDLE, one done per burst.
REQ-035 rst asserted in RUN cycle 3 -> all outputs 0 asynchronously, no done, next accept after release behaves as from reset.
